// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and small decode helpers,
// so sync generation, sprites and background agree on the same active-area bounds.
package vga_timing_pkg;

    typedef logic [15:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_counter_xy.sv
// Horizontal/vertical raster counter pair; advances on enabled cycles and reports wraps.
module vga_counter_xy
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_ce,
    output coord_t x,
    output coord_t y,
    output logic   line_wrap,
    output logic   frame_wrap
);

    localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
    localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // Next-coordinate logic; >= keeps the counters bounded even from a corrupted state.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_rst) begin
            x_d = 16'd0;
            y_d = 16'd0;
        end else if (i_ce) begin
            if (x_q >= H_MAX) begin
                x_d = 16'd0;
                if (y_q >= V_MAX) begin
                    y_d = 16'd0;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge i_clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign x          = x_q;
    assign y          = y_q;
    assign line_wrap  = ~i_rst & i_ce & (x_q >= H_MAX);
    assign frame_wrap = line_wrap & (y_q >= V_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: raster counters, sync/DE decode and a single output register
// stage that keeps hsync/vsync/DE aligned with the blanked RGB.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_v_sync,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t x, y;
    logic   line_wrap, frame_wrap;

    vga_counter_xy #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ce       (i_ce),
        .x          (x),
        .y          (y),
        .line_wrap  (line_wrap),
        .frame_wrap (frame_wrap)
    );

    logic hs_raw, vs_raw, active;

    assign hs_raw = in_range(x, HS_START, HS_END);
    assign vs_raw = in_range(y, VS_START, VS_END);
    assign active = (x < H_ACT) && (y < V_ACT);

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;
    logic       origin_q, origin_d;

    // Output stage next-state; origin_q tracks "counters sit at 0,0" without a wide compare.
    always_comb begin
        hs_d     = hs_q;
        vs_d     = vs_q;
        de_d     = de_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        origin_d = origin_q;
        if (i_rst) begin
            hs_d     = ~SYNC_POL;
            vs_d     = ~SYNC_POL;
            de_d     = 1'b0;
            red_d    = 8'h00;
            green_d  = 8'h00;
            blue_d   = 8'h00;
            origin_d = 1'b1;
        end else if (i_ce) begin
            hs_d     = sync_level(hs_raw, SYNC_POL);
            vs_d     = sync_level(vs_raw, SYNC_POL);
            de_d     = active;
            red_d    = active ? i_red   : 8'h00;
            green_d  = active ? i_green : 8'h00;
            blue_d   = active ? i_blue  : 8'h00;
            origin_d = line_wrap ? frame_wrap : 1'b0;
        end else begin
            hs_d     = hs_q;
            vs_d     = vs_q;
            de_d     = de_q;
            red_d    = red_q;
            green_d  = green_q;
            blue_d   = blue_q;
            origin_d = origin_q;
        end
    end

    // Output register stage.
    always_ff @(posedge i_clk) begin
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        de_q     <= de_d;
        red_q    <= red_d;
        green_q  <= green_d;
        blue_q   <= blue_d;
        origin_q <= origin_d;
    end

    assign o_x           = x;
    assign o_y           = y;
    assign o_v_sync      = sync_level(vs_raw, SYNC_POL);
    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_de          = de_q;
    assign o_red         = red_q;
    assign o_green       = green_q;
    assign o_blue        = blue_q;
    // Qualified by i_ce so the pulse marks exactly the one enabled cycle at the origin.
    assign o_frame_start = i_ce & ~i_rst & origin_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a scaled raster (55x13) so whole frames stay short.
module tb_vga_sync_gen;

    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ce = 1'b0;
    logic [7:0]  i_red = 8'h00, i_green = 8'h00, i_blue = 8'h00;
    logic [15:0] o_x, o_y;
    logic        o_v_sync, o_hs, o_vs, o_de, o_frame_start;
    logic [7:0]  o_red, o_green, o_blue;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_ce          (i_ce),
        .i_red         (i_red),
        .i_green       (i_green),
        .i_blue        (i_blue),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_v_sync      (o_v_sync),
        .o_hs          (o_hs),
        .o_vs          (o_vs),
        .o_de          (o_de),
        .o_red         (o_red),
        .o_green       (o_green),
        .o_blue        (o_blue),
        .o_frame_start (o_frame_start)
    );

    typedef struct {
        int          adv;
        logic        ce;
        logic [23:0] rgb;
        logic [15:0] x;
        logic [15:0] y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        vsy;
        logic        fs;
        logic [23:0] orgb;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first_x, t0, errs, nfs, fs_t[2];
        int ex, ey, pex, pey;
        logic found, ce_now;

        // {adv, ce, rgb in, x, y, hs, vs, de, v_sync, frame_start, rgb out}
        vecs[0]  = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[1]  = '{38,  1'b1, 24'h123456, 16'd39, 16'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h123456};
        vecs[2]  = '{1,   1'b1, 24'h123456, 16'd40, 16'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h123456};
        vecs[3]  = '{1,   1'b1, 24'hABCDEF, 16'd41, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[4]  = '{3,   1'b1, 24'hFFFFFF, 16'd44, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[5]  = '{1,   1'b1, 24'hFFFFFF, 16'd45, 16'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[6]  = '{5,   1'b1, 24'hFFFFFF, 16'd50, 16'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[7]  = '{1,   1'b1, 24'hFFFFFF, 16'd51, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[8]  = '{3,   1'b1, 24'hFFFFFF, 16'd54, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[9]  = '{1,   1'b1, 24'hFFFFFF, 16'd0,  16'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[10] = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[11] = '{274, 1'b1, 24'hFFFFFF, 16'd0,  16'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[12] = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[13] = '{109, 1'b1, 24'hFFFFFF, 16'd0,  16'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[14] = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[15] = '{109, 1'b1, 24'hFFFFFF, 16'd0,  16'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[16] = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[17] = '{163, 1'b1, 24'hFFFFFF, 16'd54, 16'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[18] = '{1,   1'b0, 24'hFFFFFF, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[19] = '{0,   1'b1, 24'hFFFFFF, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
        vecs[20] = '{1,   1'b1, 24'hFFFFFF, 16'd1,  16'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF};

        // Reset with i_ce low must still load the idle state.
        i_rst = 1'b1; i_ce = 1'b0; i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
        repeat (3) tick();
        chk("rst_x", o_x, 0);  chk("rst_y", o_y, 0);
        chk("rst_hs", o_hs, 1); chk("rst_vs", o_vs, 1); chk("rst_vsync", o_v_sync, 1);
        chk("rst_de", o_de, 0); chk("rst_rgb", {o_red, o_green, o_blue}, 0);
        chk("rst_fs", o_frame_start, 0);
        i_rst = 1'b0; i_ce = 1'b1;
        #1;
        chk("rel_fs", o_frame_start, 1);

        for (int i = 0; i < 21; i++) begin
            i_ce = 1'b1;
            {i_red, i_green, i_blue} = vecs[i].rgb;
            for (int k = 0; k < vecs[i].adv; k++) tick();
            i_ce = vecs[i].ce;
            #1;
            chk($sformatf("v%0d_x", i), o_x, vecs[i].x);
            chk($sformatf("v%0d_y", i), o_y, vecs[i].y);
            chk($sformatf("v%0d_hs", i), o_hs, vecs[i].hs);
            chk($sformatf("v%0d_vs", i), o_vs, vecs[i].vs);
            chk($sformatf("v%0d_de", i), o_de, vecs[i].de);
            chk($sformatf("v%0d_vsync", i), o_v_sync, vecs[i].vsy);
            chk($sformatf("v%0d_fs", i), o_frame_start, vecs[i].fs);
            chk($sformatf("v%0d_rgb", i), {o_red, o_green, o_blue}, vecs[i].orgb);
        end

        // hsync pulse width over one full line
        i_ce = 1'b1; cnt = 0; first_x = -1;
        for (int k = 0; k < HT; k++) begin
            tick();
            if (o_hs == 1'b0) begin
                if (first_x < 0) first_x = int'(o_x);
                cnt++;
            end
        end
        chk("hs_width", cnt, HS);
        chk("hs_first_x", first_x, HA + HF + 1);

        // free-run frame period
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick();
            found = o_frame_start;
        end
        chk("fs_seen", found, 1);
        found = 1'b0; t0 = 0;
        for (int k = 1; k <= 2000 && !found; k++) begin
            tick();
            if (o_frame_start) begin found = 1'b1; t0 = k; end
        end
        chk("fs_period", t0, HT * VT);

        // i_ce every 4th cycle against a small coordinate model
        ex = 0; ey = 0; pex = HT - 1; pey = VT - 1; errs = 0; nfs = 0;
        for (int c = 0; c < 4 * HT * VT + 4; c++) begin
            ce_now = (c % 4 == 0);
            i_ce = ce_now;
            #1;
            if (o_x !== 16'(ex) || o_y !== 16'(ey)) errs++;
            if (o_de !== ((pex < HA) && (pey < VA))) errs++;
            if (o_hs !== !((pex >= HA + HF) && (pex < HA + HF + HS))) errs++;
            if (o_frame_start !== (ce_now && ex == 0 && ey == 0)) errs++;
            if (o_frame_start === 1'b1) begin
                if (nfs < 2) fs_t[nfs] = c;
                nfs++;
            end
            tick();
            if (ce_now) begin
                pex = ex; pey = ey;
                if (ex == HT - 1) begin
                    ex = 0;
                    ey = (ey == VT - 1) ? 0 : ey + 1;
                end else begin
                    ex = ex + 1;
                end
            end
        end
        chk("ce_track_errs", errs, 0);
        chk("ce_fs_count", nfs, 2);
        chk("ce_frame_period", (nfs >= 2) ? fs_t[1] - fs_t[0] : 0, 4 * HT * VT);

        // reset mid-frame inside both sync pulses
        i_ce = 1'b1; found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick();
            found = (o_x == 16'd46) && (o_y == 16'd9);
        end
        chk("mid_reached", found, 1);
        chk("mid_hs", o_hs, 0); chk("mid_vs", o_vs, 0); chk("mid_vsync", o_v_sync, 0);
        i_rst = 1'b1; i_ce = 1'b0;
        tick();
        chk("mrst_x", o_x, 0); chk("mrst_y", o_y, 0);
        chk("mrst_hs", o_hs, 1); chk("mrst_vs", o_vs, 1); chk("mrst_vsync", o_v_sync, 1);
        chk("mrst_de", o_de, 0); chk("mrst_rgb", {o_red, o_green, o_blue}, 0);
        chk("mrst_fs", o_frame_start, 0);
        i_rst = 1'b0; i_ce = 1'b1;
        #1;
        chk("mrel_fs", o_frame_start, 1);
        tick();
        chk("mrel_x", o_x, 1); chk("mrel_fs_drop", o_frame_start, 0); chk("mrel_hs", o_hs, 1);

        // coordinate passthrough proves one-cycle RGB alignment
        i_green = 8'h00; i_blue = 8'h00; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            i_red = o_x[7:0];
            tick();
            found = (o_x == 16'd38);
        end
        chk("pt_reached", found, 1);
        chk("pt_red", o_red, 8'd37);
        chk("pt_de", o_de, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
